obi_mem_arbiter: RTL and testbench

Arbitrates two core-side OBI-style request ports (instruction fetch and data load/store) onto one shared memory port, so the core can run from a single-ported RAM model in the example testbench. It sits between `cv32e40p_top` and the memory-mapped RAM. It tracks in-order outstanding transactions in an ID FIFO and routes each response back to the port that issued it. Arbitration is fixed-priority or round-robin, selected at compile time.

---
 rtl/obi_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-master (instr/data) to one-port OBI arbiter with an in-order response-ID FIFO.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-instr priority.
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [31:0]           instr_rdata_o,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,

    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,

    output logic                  busy_o,
    output logic                  spurious_rvalid_o
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    // Handshake: a request transfers in the cycle where req and gnt are both high;
    // each transfer returns exactly one rvalid later, in issue order (writes included).
    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       lock_q, lock_id_q;
    logic                       spurious_q;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic                       rr_last_q;
`endif

    logic fifo_empty, fifo_full, sel_id, mem_fire, pop, head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign head_id    = id_mem[rd_ptr];

    // A pending, ungranted request keeps its master selected so fields stay stable.
    always_comb begin
        sel_id = 1'b0;
        if (lock_q) begin
            sel_id = lock_id_q;
        end
`ifdef OBI_ARB_ROUND_ROBIN_EN
        else if (instr_req_i && data_req_i) begin
            sel_id = ~rr_last_q;
        end
`endif
        else begin
            sel_id = data_req_i;
        end
    end

    assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
    assign mem_fire    = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = mem_fire & ~sel_id;
    assign data_gnt_o  = mem_fire & sel_id;

    assign mem_addr_o  = sel_id ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel_id ? data_we_i    : 1'b0;
    assign mem_be_o    = sel_id ? data_be_i    : 4'hF;
    assign mem_wdata_o = sel_id ? data_wdata_i : 32'h0;

    assign pop            = mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = pop & ~head_id;
    assign data_rvalid_o  = pop & head_id;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o            = ~fifo_empty;
    assign spurious_rvalid_o = spurious_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_mem     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            spurious_q <= 1'b0;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            if (mem_fire) begin
                id_mem[wr_ptr] <= sel_id;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({mem_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (mem_fire) begin
                lock_q <= 1'b0;
            end else if (mem_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel_id;
            end

            if (mem_rvalid_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
`ifdef OBI_ARB_ROUND_ROBIN_EN
            if (mem_fire) begin
                rr_last_q <= sel_id;
            end
`endif
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios then random traffic, checked against a queue-based model.
// Honors OBI_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_obi_mem_arbiter;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] instr_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, mem_rdata_i = '0;
    logic [3:0]  data_be_i = '0;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;

    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o, busy_o, spurious_rvalid_o;
    logic [3:0]  mem_be_o;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding IDs in issue order, plus lock/arbitration memory.
    bit m_q[$];
    bit m_lock, m_lock_id, m_rr_last, m_spur;

    obi_mem_arbiter #(.MAX_OUTSTANDING(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .spurious_rvalid_o(spurious_rvalid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_lock    = 1'b0;
        m_lock_id = 1'b0;
        m_rr_last = 1'b1;
        m_spur    = 1'b0;
    endtask

    // Compare every output against the model at negedge, then advance the model at posedge.
    task automatic step();
        bit full, ereq, esel, efire, had, head;
        @(negedge clk_i);
        full = (m_q.size() == DEPTH);
        had  = (m_q.size() > 0);
        head = had ? m_q[0] : 1'b0;
        ereq = (instr_req_i || data_req_i) && !full;
        if (m_lock)
            esel = m_lock_id;
        else if (instr_req_i && data_req_i)
`ifdef OBI_ARB_ROUND_ROBIN_EN
            esel = !m_rr_last;
`else
            esel = 1'b1;
`endif
        else
            esel = data_req_i;
        efire = ereq && mem_gnt_i;

        chk("mem_req", {31'b0, mem_req_o}, {31'b0, ereq});
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, efire && !esel});
        chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, efire && esel});
        if (ereq) begin
            chk("mem_addr", mem_addr_o, esel ? data_addr_i : instr_addr_i);
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, esel ? data_we_i : 1'b0});
            chk("mem_be", {28'b0, mem_be_o}, {28'b0, esel ? data_be_i : 4'hF});
            chk("mem_wdata", mem_wdata_o, esel ? data_wdata_i : 32'h0);
        end
        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, mem_rvalid_i && had && !head});
        chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, mem_rvalid_i && had && head});
        chk("instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("data_rdata", data_rdata_o, mem_rdata_i);
        chk("busy", {31'b0, busy_o}, {31'b0, had});
        chk("spurious", {31'b0, spurious_rvalid_o}, {31'b0, m_spur});

        @(posedge clk_i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            if (mem_rvalid_i && had) void'(m_q.pop_front());
            if (mem_rvalid_i && !had) m_spur = 1'b1;
            if (efire) begin
                m_q.push_back(esel);
                m_rr_last = esel;
                m_lock    = 1'b0;
            end else if (ereq) begin
                m_lock    = 1'b1;
                m_lock_id = esel;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) step();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held with both masters requesting
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b0;
        instr_addr_i = 32'h100; data_addr_i = 32'h2000;
        #1;
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd1);
        chk("rst_instr_gnt", {31'b0, instr_gnt_o}, 32'd0);
        chk("rst_data_gnt", {31'b0, data_gnt_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_spurious", {31'b0, spurious_rvalid_o}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        rst_ni = 1'b1;

        // Tie: both request continuously, rvalid one cycle after each grant
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_rvalid_i = (k > 0);
            mem_rdata_i  = $urandom;
            #1;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            chk("tie_instr_gnt", {31'b0, instr_gnt_o}, {31'b0, (k % 2) == 0});
            chk("tie_data_gnt", {31'b0, data_gnt_o}, {31'b0, (k % 2) == 1});
`else
            chk("tie_instr_gnt", {31'b0, instr_gnt_o}, 32'd0);
            chk("tie_data_gnt", {31'b0, data_gnt_o}, 32'd1);
`endif
            step();
        end
        drain();

        // Lock: instr waits 3 cycles for grant, data arrives meanwhile
        mem_gnt_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h180;
        data_req_i = 1'b0; data_addr_i = 32'h2000; data_we_i = 1'b0; data_be_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) data_req_i = 1'b1;
            if (c == 3) mem_gnt_i = 1'b1;
            #1;
            chk("lock_addr", mem_addr_o, 32'h180);
            chk("lock_instr_gnt", {31'b0, instr_gnt_o}, {31'b0, c == 3});
            step();
        end
        instr_req_i = 1'b0;
        #1;
        chk("lock_data_gnt", {31'b0, data_gnt_o}, 32'd1);
        chk("lock_data_addr", mem_addr_o, 32'h2000);
        step();
        data_req_i = 1'b0; mem_gnt_i = 1'b0;
        drain();

        // Full FIFO
        instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        step(); step();
        #1;
        chk("full_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("full_busy", {31'b0, busy_o}, 32'd1);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        #1;
        chk("full_pop_mem_req", {31'b0, mem_req_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        chk("full_reassert", {31'b0, mem_req_o}, 32'd1);
        step();
        drain();

        // Routing: I, D write, I with responses on consecutive cycles
        mem_gnt_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h180;
        step();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_we_i = 1'b1;
        data_addr_i = 32'h1000; data_be_i = 4'h3; data_wdata_i = 32'hCAFE_0055;
        #1;
        chk("route_we", {31'b0, mem_we_o}, 32'd1);
        chk("route_be", {28'b0, mem_be_o}, 32'h3);
        chk("route_addr", mem_addr_o, 32'h1000);
        step();
        data_req_i = 1'b0; data_we_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h184;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA;
        #1;
        chk("route_full_req", {31'b0, mem_req_o}, 32'd0);
        chk("route_rv_a", {31'b0, instr_rvalid_o}, 32'd1);
        chk("route_rdata_a", instr_rdata_o, 32'hA);
        step();
        mem_rdata_i = 32'hB;
        #1;
        chk("route_rv_b", {31'b0, data_rvalid_o}, 32'd1);
        chk("route_rdata_b", data_rdata_o, 32'hB);
        chk("route_gnt_i2", {31'b0, instr_gnt_o}, 32'd1);
        step();
        instr_req_i = 1'b0; mem_rdata_i = 32'hC;
        #1;
        chk("route_rv_c", {31'b0, instr_rvalid_o}, 32'd1);
        chk("route_rdata_c", instr_rdata_o, 32'hC);
        step();
        mem_rvalid_i = 1'b0;
        step();
        chk("route_idle", {31'b0, busy_o}, 32'd0);

        // Spurious rvalid, sticky until reset
        mem_rvalid_i = 1'b1;
        #1;
        chk("spur_no_irv", {31'b0, instr_rvalid_o}, 32'd0);
        chk("spur_no_drv", {31'b0, data_rvalid_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("spur_sticky", {31'b0, spurious_rvalid_o}, 32'd1);
        do_reset();
        chk("spur_cleared", {31'b0, spurious_rvalid_o}, 32'd0);

        // Reset with a transaction outstanding: its response becomes spurious
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        do_reset();
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        chk("midrst_spur", {31'b0, spurious_rvalid_o}, 32'd1);
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_ni = 1'b0;
                model_reset();
            end else begin
                rst_ni = 1'b1;
            end
            instr_req_i  = ($urandom_range(0, 2) != 0);
            data_req_i   = ($urandom_range(0, 2) != 0);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
            data_addr_i  = $urandom;
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = 4'($urandom_range(0, 15));
            data_wdata_i = $urandom;
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = $urandom_range(0, 1);
            mem_rdata_i  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
